// File: rtl/lzc_seq.sv
// Sequential trailing/leading zero counter: scans CHUNK bits per cycle, result in cycle k_hit+2 (all-zero: NUM_CHUNKS+1).
// One op in flight; ready_o only in IDLE, result held until valid_o & ready_i. Macro LZC_SEQ_FIXED_LATENCY_EN forces full-length scans.
module lzc_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  parameter int MODE  = 0,
  localparam int NUM_CHUNKS = (WIDTH + CHUNK - 1) / CHUNK,
  localparam int CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  localparam int PAD_W = NUM_CHUNKS * CHUNK;
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nxt;
  logic [PAD_W-1:0] tmp, ordered;
  logic [IDX_W-1:0] k;
  logic [CHUNK-1:0] slice;
  logic [CNT_W-1:0] loc, base, hit_cnt, cnt_r;
  logic             slice_nz, last, scan_stop, hit, empty_r;

  // Reorder so the scan always walks toward increasing index; padding stays zero.
  always_comb begin
    ordered = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ordered[i] = (MODE != 0) ? data_i[WIDTH-1-i] : data_i[i];
    end
  end

  always_comb begin
    slice = tmp[int'(k)*CHUNK +: CHUNK];
    loc   = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (slice[i]) loc = CNT_W'(i);
    end
  end

  assign slice_nz = |slice;
  assign last     = (k == LAST_K);
  assign base     = CNT_W'(int'(k) * CHUNK);
  assign hit_cnt  = base + loc;

`ifdef LZC_SEQ_FIXED_LATENCY_EN
  assign scan_stop = last;
`else
  assign scan_stop = last | slice_nz;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i)   state_nxt = SCAN;
      SCAN:    if (scan_stop) state_nxt = DONE;
      DONE:    if (ready_i)   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      k       <= '0;
      cnt_r   <= '0;
      empty_r <= 1'b0;
      hit     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (valid_i) begin
            k     <= '0;
            hit   <= 1'b0;
            cnt_r <= '0;
          end
        end
        SCAN: begin
          // Only the first non-zero slice sets the result.
          if (slice_nz && !hit) begin
            cnt_r <= hit_cnt;
            hit   <= 1'b1;
          end
          if (scan_stop) empty_r <= !(hit || slice_nz);
          else           k       <= k + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Operand register is deliberately left untouched by reset.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && valid_i) tmp <= ordered;
  end

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);
  assign cnt_o   = cnt_r;
  assign empty_o = empty_r;

`ifndef SYNTHESIS
  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (MODE != 0 && MODE != 1)) begin : g_param_check
    $error("lzc_seq: illegal WIDTH/CHUNK/MODE");
  end

  a_hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i) |=> ($stable(cnt_o) && $stable(empty_o)));
`endif

endmodule

// File: tb/tb_lzc_seq.sv
// Directed bench for lzc_seq: 64-bit TZ, 64-bit LZ and 40-bit TZ instances checked against hand-computed results.
module tb_lzc_seq;

`ifdef LZC_SEQ_FIXED_LATENCY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i [3];
  logic        ready_o [3];
  logic [63:0] data_i  [3];
  logic        valid_o [3];
  logic        ready_i [3];
  logic [5:0]  cnt_o   [3];
  logic        empty_o [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lzc_seq #(.WIDTH(64), .CHUNK(16), .MODE(0)) u_tz64 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i[0]), .ready_o(ready_o[0]),
    .data_i(data_i[0]), .valid_o(valid_o[0]), .ready_i(ready_i[0]),
    .cnt_o(cnt_o[0]), .empty_o(empty_o[0]));

  lzc_seq #(.WIDTH(64), .CHUNK(16), .MODE(1)) u_lz64 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i[1]), .ready_o(ready_o[1]),
    .data_i(data_i[1]), .valid_o(valid_o[1]), .ready_i(ready_i[1]),
    .cnt_o(cnt_o[1]), .empty_o(empty_o[1]));

  lzc_seq #(.WIDTH(40), .CHUNK(16), .MODE(0)) u_tz40 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i[2]), .ready_o(ready_o[2]),
    .data_i(data_i[2][39:0]), .valid_o(valid_o[2]), .ready_i(ready_i[2]),
    .cnt_o(cnt_o[2]), .empty_o(empty_o[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_cyc(input int khit, input int nch);
    return FIXED ? nch + 1 : khit + 2;
  endfunction

  // Called just after a rising edge; returns 1ns after the accepting edge (cycle 1).
  task automatic launch(input int d, input logic [63:0] dat);
    valid_i[d] = 1'b1;
    data_i[d]  = dat;
    @(posedge clk);
    #1;
    valid_i[d] = 1'b0;
  endtask

  task automatic wait_result(input int d, output int cyc);
    cyc = 1;
    while (!valid_o[d] && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic op(input int d, input string tag, input logic [63:0] dat,
                    input int ecyc, input int ecnt, input bit eempty);
    int cyc;
    check({tag, "/rdy"}, ready_o[d], 1);
    launch(d, dat);
    wait_result(d, cyc);
    check({tag, "/cyc"}, cyc, ecyc);
    check({tag, "/cnt"}, cnt_o[d], ecnt);
    check({tag, "/empty"}, empty_o[d], eempty);
    ready_i[d] = 1'b1;
    @(posedge clk);
    #1;
    ready_i[d] = 1'b0;
    check({tag, "/idle_rdy"}, ready_o[d], 1);
    check({tag, "/idle_vld"}, valid_o[d], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit seen;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_i[i] = 1'b0;
      ready_i[i] = 1'b0;
      data_i[i]  = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst/vld", valid_o[0], 0);
    check("rst/rdy", ready_o[0], 1);
    check("rst/cnt", cnt_o[0], 0);
    check("rst/empty", empty_o[0], 0);

    op(0, "tz_b3",    64'h0000_0000_0000_0008, exp_cyc(0, 4), 3,  0);
    op(0, "tz_b48",   64'h0001_0000_0000_0000, exp_cyc(3, 4), 48, 0);
    op(0, "tz_zero",  64'h0,                   exp_cyc(3, 4), 0,  1);
    op(0, "tz_multi", 64'hF000_0000_0000_0F00, exp_cyc(0, 4), 8,  0);
    op(0, "tz_b24",   64'h0000_0000_0100_0000, exp_cyc(1, 4), 24, 0);
    op(1, "lz_msb",   64'h8000_0000_0000_0000, exp_cyc(0, 4), 0,  0);
    op(1, "lz_lsb",   64'h0000_0000_0000_0001, exp_cyc(3, 4), 63, 0);
    op(1, "lz_b40",   64'h0000_0100_0000_0000, exp_cyc(1, 4), 23, 0);
    op(1, "lz_zero",  64'h0,                   exp_cyc(3, 4), 0,  1);
    op(2, "w40_b39",  64'h0000_0080_0000_0000, exp_cyc(2, 3), 39, 0);
    op(2, "w40_zero", 64'h0,                   exp_cyc(2, 3), 0,  1);
    op(2, "w40_b0",   64'h0000_0000_0000_0001, exp_cyc(0, 3), 0,  0);

    // Backpressure: hold the result while a second operand waits on valid_i.
    launch(0, 64'h8);
    wait_result(0, cyc);
    check("bp/cyc", cyc, exp_cyc(0, 4));
    valid_i[0] = 1'b1;
    data_i[0]  = 64'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp/cnt", cnt_o[0], 3);
      check("bp/empty", empty_o[0], 0);
      check("bp/vld", valid_o[0], 1);
      check("bp/rdy", ready_o[0], 0);
    end
    ready_i[0] = 1'b1;
    @(posedge clk);
    #1;
    ready_i[0] = 1'b0;
    check("bp/rdy_after", ready_o[0], 1);
    check("bp/vld_after", valid_o[0], 0);
    @(posedge clk);
    #1;
    valid_i[0] = 1'b0;
    check("bp2/busy", ready_o[0], 0);
    wait_result(0, cyc);
    check("bp2/cyc", cyc, exp_cyc(0, 4));
    check("bp2/cnt", cnt_o[0], 4);
    check("bp2/empty", empty_o[0], 0);
    ready_i[0] = 1'b1;
    @(posedge clk);
    #1;
    ready_i[0] = 1'b0;

    // Reset in cycle 2 of a 40-bit scan aborts it.
    launch(2, 64'h0000_0080_0000_0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort/rdy", ready_o[2], 1);
    check("abort/vld", valid_o[2], 0);
    check("abort/cnt", cnt_o[2], 0);
    check("abort/empty", empty_o[2], 0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (valid_o[2]) seen = 1'b1;
    end
    check("abort/no_result", seen, 0);
    op(2, "w40_post_rst", 64'h0000_0000_0001_0000, exp_cyc(1, 3), 16, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lzc_seq.md
Name: lzc_seq

Overview:
- Sequential leading/trailing zero counter for wide vectors.
- Scans the operand in CHUNK-bit slices, one slice per cycle, and stops early at the first non-zero slice.
- Trades latency for area and timing on very wide inputs, for example FP normalisation of wide mantissas and bitmap allocators.
- Valid/ready on both sides; one operation in flight.

Parameters:
- WIDTH, 64: operand width in bits; must be >= 1.
- CHUNK, 16: bits examined per scan cycle; must satisfy 1 <= CHUNK <= WIDTH.
- MODE, 0: 0 = count trailing zeros (from LSB); 1 = count leading zeros (from MSB).
- Derived: NUM_CHUNKS = ceil(WIDTH/CHUNK); CNT_W = max(1, $clog2(WIDTH)); IDX_W = max(1, $clog2(NUM_CHUNKS)).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- valid_i  in  1  operand valid.
- ready_o  out  1  block can accept an operand.
- data_i  in  WIDTH  operand.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- cnt_o  out  CNT_W  zero count; 0 when the operand is empty.
- empty_o  out  1  operand was all zeros.

Behaviour:
- Reset: after any rising edge with rst_i=1, state=IDLE, valid_o=0, cnt_o=0, empty_o=0, chunk index=0.
  - Reset mid-SCAN or in DONE aborts the operation; no result is emitted and the data register is not cleared.
- FSM states: IDLE, SCAN, DONE. ready_o = (state==IDLE), decoded combinationally from the state register, with no bypass.
- IDLE:
  - On valid_i & ready_o, register the operand as tmp and go to SCAN with k=0.
  - tmp[i] = MODE ? data_i[WIDTH-1-i] : data_i[i], so the scan is always toward increasing index.
- SCAN, examines slice k = tmp[k*CHUNK +: CHUNK]:
  - Bits at or above WIDTH in the final partial slice read as 0.
  - If the slice is non-zero: cnt = k*CHUNK + (trailing zeros within the slice), empty=0, go to DONE.
  - Else if k==NUM_CHUNKS-1: cnt=0, empty=1, go to DONE.
  - Else k <= k+1.
- Latency: the accepting cycle is cycle 0. valid_o rises in cycle k_hit+2, where k_hit is the index of the first non-zero slice. An all-zero operand gives cycle NUM_CHUNKS+1.
- DONE:
  - valid_o=1; cnt_o and empty_o are registered and must stay stable until valid_o & ready_i.
  - On that handshake: valid_o=0 and state=IDLE, so ready_o=1 in the next cycle.
  - Throughput is at most one operation per k_hit+3 cycles.
- valid_i while not in IDLE is ignored. The upstream must hold its data under the standard rule.
- Arithmetic: k*CHUNK + local count always fits CNT_W because the result is <= WIDTH-1.
- Degenerate sizes:
  - CHUNK==WIDTH: single SCAN cycle; result appears in cycle 2.
  - WIDTH==1: cnt_o is always 0 and empty_o = ~data_i[0].
- Simulation-only assertions: parameter legality, and stability of cnt_o/empty_o while valid_o & ~ready_i.

Optional Feature:
- Macro: LZC_SEQ_FIXED_LATENCY_EN.
- Defined:
  - SCAN always runs all NUM_CHUNKS cycles.
  - The first non-zero slice is latched into the result registers; later slices are examined but do not change the result.
  - valid_o always rises in cycle NUM_CHUNKS+1, giving data-independent timing with no timing side channel.
- Undefined: early-exit behaviour as described under Behaviour.

Test Plan (WIDTH=64, CHUNK=16 unless noted; cycle 0 is the accepting cycle; feature undefined unless noted):
- MODE=0, data=64'h0000_0000_0000_0008 -> valid_o in cycle 2, cnt_o=3, empty_o=0.
- MODE=0, data=64'h0001_0000_0000_0000 -> valid_o in cycle 5, cnt_o=48; then data=0 -> valid_o in cycle 5, cnt_o=0, empty_o=1.
- MODE=1:
  - data=64'h8000_0000_0000_0000 -> cycle 2, cnt_o=0.
  - data=64'h0000_0000_0000_0001 -> cycle 5, cnt_o=63.
  - data=64'h0000_0100_0000_0000 -> cycle 3, cnt_o=23.
- Backpressure: ready_i=0 for 3 cycles in DONE -> cnt_o/empty_o stable, ready_o=0, and a second operand held on valid_i is accepted only in the cycle after the result handshake.
- WIDTH=40, CHUNK=16, MODE=0:
  - data bit 39 set -> cycle 4, cnt_o=39.
  - data=0 -> cycle 4, empty_o=1 (padding bits never produce a hit).
  - rst_i=1 in cycle 2 of a scan -> no valid_o, ready_o=1 the cycle after reset deasserts.
- LZC_SEQ_FIXED_LATENCY_EN defined, data=64'h0000_0000_0000_0008 and 64'h0001_0000_0000_0000 -> both valid in cycle 5, cnt_o=3 and 48 respectively.
